// File: rtl/multicycle_adder_ctrl_pkg.sv
// mcadd_pkg: shared types and default widths
// for the multicycle chunked adder controller.
package mcadd_pkg;

  localparam int MCADD_DATA_WIDTH  = 32;
  localparam int MCADD_CHUNK_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mcadd_state_e;

endpackage

// File: rtl/multicycle_adder_ctrl_if.sv
// Operand/result valid-ready bundle for the
// multicycle adder controller.
interface multicycle_adder_ctrl_if
  import mcadd_pkg::*;
#(
  parameter int DATA_WIDTH = MCADD_DATA_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH:0]   sum;
  logic                  busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, busy
  );

endinterface

// File: rtl/multicycle_adder_ctrl_rca.sv
// rca: plain ripple-carry adder, one full
// adder cell per bit.
module rca #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  cin_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  cout_o
);

  logic [DATA_WIDTH:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) |
                      (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[DATA_WIDTH];

endmodule

// File: rtl/multicycle_adder_ctrl.sv
// multicycle_adder_ctrl: adds a+b+cin one chunk per cycle
// on a shared rca slice. Optional MCADD_OVF_EN adds ovf.
module multicycle_adder_ctrl
  import mcadd_pkg::*;
#(
  parameter int DATA_WIDTH  = MCADD_DATA_WIDTH,
  parameter int CHUNK_WIDTH = MCADD_CHUNK_WIDTH
) (
  input  logic clk,
  input  logic reset,
  multicycle_adder_ctrl_if.slave bus
`ifdef MCADD_OVF_EN
  ,
  output logic ovf
`endif
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W  = (NUM_CHUNKS > 1) ?
                          $clog2(NUM_CHUNKS) : 1;
  localparam int BASE_W = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_CHUNKS - 1);

  if ((CHUNK_WIDTH > DATA_WIDTH) ||
      (DATA_WIDTH % CHUNK_WIDTH != 0)) begin : g_bad_cfg
    $error("CHUNK_WIDTH must divide DATA_WIDTH");
  end

  mcadd_state_e          state_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  carry_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH:0]   sum_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  busy_q;
`ifdef MCADD_OVF_EN
  logic                  ovf_q;
`endif

  logic [BASE_W-1:0]      base;
  logic [CHUNK_WIDTH-1:0] a_sl;
  logic [CHUNK_WIDTH-1:0] b_sl;
  logic [CHUNK_WIDTH-1:0] sl_sum_d;
  logic                   sl_co_d;

  assign base = BASE_W'(idx_q) * BASE_W'(CHUNK_WIDTH);
  assign a_sl = a_q[base +: CHUNK_WIDTH];
  assign b_sl = b_q[base +: CHUNK_WIDTH];

  rca #(
    .DATA_WIDTH (CHUNK_WIDTH)
  ) u_rca (
    .a_i    (a_sl),
    .b_i    (b_sl),
    .cin_i  (carry_q),
    .sum_o  (sl_sum_d),
    .cout_o (sl_co_d)
  );

  // Control FSM: accept, walk the chunks, hold result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MCADD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            carry_q    <= bus.cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q[base +: CHUNK_WIDTH] <= sl_sum_d;
          carry_q <= sl_co_d;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            sum_q[DATA_WIDTH] <= sl_co_d;
            out_valid_q       <= 1'b1;
            state_q           <= DONE;
`ifdef MCADD_OVF_EN
            ovf_q <= (a_q[DATA_WIDTH-1] ==
                      b_q[DATA_WIDTH-1]) &&
                     (sl_sum_d[CHUNK_WIDTH-1] !=
                      a_q[DATA_WIDTH-1]);
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.busy      = busy_q;
`ifdef MCADD_OVF_EN
  assign ovf           = ovf_q;
`endif

endmodule
